button_input: RTL and testbench
===============================

# button_input

Debounced push-button input block: the input-side counterpart to the tick-driven LED output logic. It takes raw, active-low, asynchronous board button pins and synchronises and debounces them on a shared slow sample tick. Per button it produces a clean pressed level plus single-cycle press, release and long-press event pulses for downstream state machines such as LED pattern control. It sits directly behind the board pins, in the `sysclk` domain.

## Interface
- `CLOCK_FREQ`, 12000000: `sysclk` frequency in Hz; documents the sample rate only.
- `NUM_BUTTONS`, 2: number of channels, 1..4.
- `SAMPLE_DIV`, 12000: `sysclk` cycles per sample tick (1 ms at 12 MHz); must be ≥ 2.
- `DEBOUNCE_SAMPLES`, 10: consecutive disagreeing samples needed to flip a level; must be ≥ 1.
- `LONG_PRESS_SAMPLES`, 1000: ticks of held level before `long_press` fires; must be ≥ 1.
- `sysclk` in 1: the single clock; every flop is clocked on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `btn_n` in NUM_BUTTONS: raw button pins, active low, asynchronous, bouncy.
- `level` out NUM_BUTTONS: debounced state, 1 = pressed.
- `press` out NUM_BUTTONS: one-cycle pulse on each debounced 0→1 transition.
- `release` out NUM_BUTTONS: one-cycle pulse on each debounced 1→0 transition.
- `long_press` out NUM_BUTTONS: one-cycle pulse, at most once per press.
- `debug` out 8: bits [3:0] = `level` zero-extended; [4] = OR of `press`; [5] = OR of `release`; [6] = OR of `long_press`; [7] = `tick`.

## Operation
- **Synchroniser:** two flops per bit, reset value 1 (not pressed). The synchronised sample `s = ~sync2`.
- **Tick generator:** counter `div` runs 0..SAMPLE_DIV-1; reset value 0.
  - `tick` is high during the one cycle where `div == SAMPLE_DIV-1`; `div` wraps to 0 on that cycle.
  - One generator is shared by all channels.
- **Per-channel state machine** (`level` is 1 in every state except RELEASED), updated only on `tick` cycles:
  - **Debounce counter:** `cnt` counts consecutive samples with `s != level`.
    - A sample with `s == level` clears `cnt`.
    - A disagreeing sample with `cnt == DEBOUNCE_SAMPLES-1` flips the level and clears `cnt`.
  - **RELEASED → PRESSED:** on debounced press; `press` pulses; `hold` is cleared.
  - **PRESSED:** each tick increments `hold`. When `hold` reaches LONG_PRESS_SAMPLES, `long_press` pulses and the state becomes HELD.
  - **HELD:** `hold` saturates; no further `long_press` pulses.
  - **PRESSED or HELD → RELEASED:** on debounced release; `release` pulses.
- **Output timing:** `level`, `press`, `release` and `long_press` are registered. Each pulse is high for exactly one `sysclk` cycle, and that cycle is the first cycle of the new `level` value.
- **Widths:** `cnt` is $clog2(DEBOUNCE_SAMPLES+1) bits and `hold` is $clog2(LONG_PRESS_SAMPLES+1) bits, both unsigned. Neither counter ever wraps.
- **Same-tick events:** if the debounced release and the `hold` terminal count land on the same tick, the release wins and `long_press` does not pulse.
- **Reset:** all outputs are 0 and every channel enters RELEASED. Asserting reset mid-press clears `level` with no `release` pulse. No pulses occur in the cycle after reset deasserts.
- **Channel independence:** channels are fully independent, so simultaneous presses pulse in the same cycle.

## Timing
- **Press latency:** from a stable edge on `btn_n` to `press` is 2 synchroniser cycles plus 0..SAMPLE_DIV-1 cycles of tick phase, plus (DEBOUNCE_SAMPLES-1)·SAMPLE_DIV cycles, plus 1 output-register cycle. Release latency is identical.
- **Long-press latency:** `long_press` follows `press` by exactly LONG_PRESS_SAMPLES·SAMPLE_DIV cycles when no release occurs.
- **Bounce rejection:** a glitch shorter than (DEBOUNCE_SAMPLES-1)·SAMPLE_DIV cycles cannot change `level`.
- **Combinational paths:** none from `btn_n` to any output. `debug` is combinational from registered signals only.

## Structure
- **Shared package `button_pkg`:** holds the state encodings RELEASED=2'b00, PRESSED=2'b01, HELD=2'b10, plus the debug bit-index constants.
- **Top level `button_input`:** contains the synchroniser, the tick generator and the debug mapping.
- **Sub-module `button_channel`:** one instance per button, generated; contains `cnt`, `hold`, the state register and the pulse outputs. A default state decode returns the channel to RELEASED.

## Test plan
All scenarios use SAMPLE_DIV=4, DEBOUNCE_SAMPLES=3, LONG_PRESS_SAMPLES=8, NUM_BUTTONS=2.
- **Reset:** hold `reset` for 5 cycles with `btn_n`=2'b00 → `level`, `press`, `release`, `long_press` and `debug[6:0]` are all 0 during reset.
- **Clean press:** drive `btn_n[0]` from 1 to 0 and hold → exactly one `press[0]` pulse, 11..14 cycles after the edge; `level[0]`=1 from that cycle; `btn_n[1]`=1 so channel 1 stays quiet.
- **Bounce rejection:** toggle `btn_n[0]` every 5 cycles for 60 cycles, then hold it at 1 → no `press` or `release` pulse and `level[0]` stays 0.
- **Long press:** hold `btn_n[0]` at 0 after `press` → one `long_press[0]` exactly 32 cycles after `press` and no repeat over 200 more cycles. Then drive 1 → one `release[0]` pulse and `level[0]`=0.
- **Simultaneous press:** drive both bits of `btn_n` low on the same cycle → `press`=2'b11 in a single cycle and `debug[4]`=1 in that cycle.
- **Reset mid-press:** while in HELD, assert `reset` for 1 cycle with the button still low → `level` is 0 the next cycle, with no `release` pulse. A new `press` follows after the full debounce latency.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the debounced push-button input block.
package button_pkg;

  // Per-channel debounce/hold state; level is 1 in every state except StReleased.
  typedef enum logic [1:0] {
    StReleased = 2'b00,
    StPressed  = 2'b01,
    StHeld     = 2'b10
  } btn_state_e;

  // Largest supported channel count; also the width of the level field in debug.
  localparam int unsigned MaxButtons = 4;

  // Bit positions within the debug bus.
  localparam int unsigned DbgLevelLsb  = 0;
  localparam int unsigned DbgLevelMsb  = 3;
  localparam int unsigned DbgPress     = 4;
  localparam int unsigned DbgRelease   = 5;
  localparam int unsigned DbgLongPress = 6;
  localparam int unsigned DbgTick      = 7;

endpackage

// File: rtl/button_channel.sv
// One debounced button channel: consecutive-sample debounce counter, hold timer,
// RELEASED/PRESSED/HELD state register and registered single-cycle event pulses.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DebounceSamples  = 10,
  parameter int unsigned LongPressSamples = 1000
) (
  input  logic sysclk,
  input  logic reset,
  input  logic tick_i,
  input  logic sample_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  localparam int unsigned CntW  = $clog2(DebounceSamples + 1);
  localparam int unsigned HoldW = $clog2(LongPressSamples + 1);

  localparam logic [CntW-1:0]  CntLast  = CntW'(DebounceSamples - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LongPressSamples);

  btn_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [HoldW-1:0] hold_inc;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_press_q, long_press_d;
  logic             flip;

  assign level_o      = (state_q != StReleased);
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_press_q;

  // Next-state: debounce on tick, then advance the press/hold state machine.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_press_d = 1'b0;
    flip         = 1'b0;
    hold_inc     = hold_q + 1'b1;

    if (tick_i) begin
      if (sample_i == level_o) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        cnt_d = '0;
        flip  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      StReleased: begin
        if (flip) begin
          state_d = StPressed;
          hold_d  = '0;
          press_d = 1'b1;
        end
      end
      StPressed: begin
        // A release on the terminal-count tick takes priority over long_press.
        if (flip) begin
          state_d   = StReleased;
          release_d = 1'b1;
        end else if (tick_i) begin
          hold_d = hold_inc;
          if (hold_inc == HoldLast) begin
            state_d      = StHeld;
            long_press_d = 1'b1;
          end
        end
      end
      StHeld: begin
        // hold stays at its terminal value, so long_press cannot repeat.
        if (flip) begin
          state_d   = StReleased;
          release_d = 1'b1;
        end
      end
      default: begin
        state_d = StReleased;
        cnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State, counters and event pulses.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= StReleased;
      cnt_q        <= '0;
      hold_q       <= '0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_press_q <= long_press_d;
    end
  end

endmodule

// File: rtl/button_input.sv
// Debounced push-button input: synchronises active-low board pins, divides sysclk
// down to a shared sample tick and runs one debounce channel per button.
module button_input
  import button_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ         = 12000000,
  parameter int unsigned NUM_BUTTONS        = 2,
  parameter int unsigned SAMPLE_DIV         = 12000,
  parameter int unsigned DEBOUNCE_SAMPLES   = 10,
  parameter int unsigned LONG_PRESS_SAMPLES = 1000
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_n,
  output logic [NUM_BUTTONS-1:0] level,
  output logic [NUM_BUTTONS-1:0] press,
  // Named release_pulse because "release" is a reserved word in the language.
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] long_press,
  output logic [7:0]             debug
);

  localparam int unsigned DivW = $clog2(SAMPLE_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(SAMPLE_DIV - 1);

  // A misconfigured instance never ticks, holding every channel released.
  localparam bit ParamsOk = (NUM_BUTTONS >= 1) && (NUM_BUTTONS <= MaxButtons) &&
                            (SAMPLE_DIV >= 2) && (DEBOUNCE_SAMPLES >= 1) &&
                            (LONG_PRESS_SAMPLES >= 1) && (CLOCK_FREQ >= SAMPLE_DIV);

  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] sample;
  logic [DivW-1:0]        div_q, div_d;
  logic                   tick;

  // Two-flop synchroniser; resets to the idle (not pressed) pin level.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  assign sample = ~sync2_q;

  // Sample-tick divider: tick marks the last cycle of each SAMPLE_DIV period.
  always_comb begin
    tick  = ParamsOk && (div_q == DivLast);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Divider counter register.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    button_channel #(
      .DebounceSamples (DEBOUNCE_SAMPLES),
      .LongPressSamples(LONG_PRESS_SAMPLES)
    ) u_chan (
      .sysclk      (sysclk),
      .reset       (reset),
      .tick_i      (tick),
      .sample_i    (sample[i]),
      .level_o     (level[i]),
      .press_o     (press[i]),
      .release_o   (release_pulse[i]),
      .long_press_o(long_press[i])
    );
  end

  // Debug bus built only from registered state and the divider compare.
  always_comb begin
    logic [MaxButtons-1:0] level_ext;
    level_ext                      = '0;
    level_ext[NUM_BUTTONS-1:0]     = level;
    debug                          = '0;
    debug[DbgLevelMsb:DbgLevelLsb] = level_ext;
    debug[DbgPress]                = |press;
    debug[DbgRelease]              = |release_pulse;
    debug[DbgLongPress]            = |long_press;
    debug[DbgTick]                 = tick;
  end

endmodule

// File: tb/tb_button_input.sv
// Directed bench for button_input with SAMPLE_DIV=4, DEBOUNCE_SAMPLES=3,
// LONG_PRESS_SAMPLES=8, NUM_BUTTONS=2.
module tb_button_input;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic [1:0] btn_n  = 2'b00;
  logic [1:0] level, press, release_pulse, long_press;
  logic [7:0] debug;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  // Event monitor state, written only by the negedge monitor.
  int unsigned press_cnt[2] = '{0, 0};
  int unsigned rel_cnt[2]   = '{0, 0};
  int unsigned long_cnt[2]  = '{0, 0};
  int unsigned press_cyc[2] = '{0, 0};
  int unsigned long_cyc[2]  = '{0, 0};
  logic        press_lvl[2] = '{1'b0, 1'b0};
  int unsigned both_cnt = 0;
  logic        both_dbg = 1'b0;

  // Snapshots taken by the main sequence.
  int unsigned b_press[2], b_rel[2], b_long[2], b_both;
  int unsigned t0, lat, mark;

  button_input #(
    .CLOCK_FREQ        (12000000),
    .NUM_BUTTONS       (2),
    .SAMPLE_DIV        (4),
    .DEBOUNCE_SAMPLES  (3),
    .LONG_PRESS_SAMPLES(8)
  ) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .btn_n        (btn_n),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .debug        (debug)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    for (int i = 0; i < 2; i++) begin
      if (press[i] === 1'b1) begin
        press_cnt[i] <= press_cnt[i] + 1;
        press_cyc[i] <= cyc;
        press_lvl[i] <= level[i];
      end
      if (release_pulse[i] === 1'b1) rel_cnt[i] <= rel_cnt[i] + 1;
      if (long_press[i] === 1'b1) begin
        long_cnt[i] <= long_cnt[i] + 1;
        long_cyc[i] <= cyc;
      end
    end
    if (press === 2'b11) begin
      both_cnt <= both_cnt + 1;
      both_dbg <= debug[4];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      b_press[i] = press_cnt[i];
      b_rel[i]   = rel_cnt[i];
      b_long[i]  = long_cnt[i];
    end
    b_both = both_cnt;
  endtask

  initial begin
    // Reset with both buttons held low: everything stays quiet.
    reset = 1'b1;
    btn_n = 2'b00;
    repeat (5) begin
      step(1);
      check_eq("rst_level", 32'(level), 0);
      check_eq("rst_press", 32'(press), 0);
      check_eq("rst_release", 32'(release_pulse), 0);
      check_eq("rst_long", 32'(long_press), 0);
      check_eq("rst_debug", 32'(debug[6:0]), 0);
    end
    reset = 1'b0;
    btn_n = 2'b11;
    step(1);
    check_eq("post_rst_press", 32'(press), 0);
    check_eq("post_rst_release", 32'(release_pulse), 0);
    check_eq("post_rst_long", 32'(long_press), 0);
    step(20);

    // Clean press on channel 0.
    snap();
    t0 = cyc;
    btn_n[0] = 1'b0;
    step(20);
    lat = press_cyc[0] - t0;
    check_eq("press0_count", press_cnt[0] - b_press[0], 1);
    check_eq("press0_latency_11_14", 32'(lat >= 11 && lat <= 14), 1);
    check_eq("press0_level_at_pulse", 32'(press_lvl[0]), 1);
    check_eq("press_level", 32'(level), 32'b01);
    check_eq("press1_quiet", press_cnt[1] - b_press[1], 0);

    // Long press: one pulse exactly 32 cycles after press, no repeat.
    step(40);
    check_eq("long0_count", long_cnt[0] - b_long[0], 1);
    check_eq("long0_latency", long_cyc[0] - press_cyc[0], 32);
    step(200);
    check_eq("long0_no_repeat", long_cnt[0] - b_long[0], 1);
    check_eq("long1_quiet", long_cnt[1] - b_long[1], 0);
    check_eq("held_level", 32'(level), 32'b01);

    // Release after long press.
    btn_n[0] = 1'b1;
    step(20);
    check_eq("release0_count", rel_cnt[0] - b_rel[0], 1);
    check_eq("release_level", 32'(level), 0);
    check_eq("release1_quiet", rel_cnt[1] - b_rel[1], 0);

    // Bounce rejection: 5-cycle toggles never span three ticks.
    snap();
    for (int k = 0; k < 12; k++) begin
      btn_n[0] = ~btn_n[0];
      step(5);
    end
    btn_n[0] = 1'b1;
    step(20);
    check_eq("bounce_press", press_cnt[0] - b_press[0], 0);
    check_eq("bounce_release", rel_cnt[0] - b_rel[0], 0);
    check_eq("bounce_level", 32'(level), 0);

    // Simultaneous press on both channels.
    snap();
    btn_n = 2'b00;
    step(60);
    check_eq("simul_press0", press_cnt[0] - b_press[0], 1);
    check_eq("simul_press1", press_cnt[1] - b_press[1], 1);
    check_eq("simul_same_cycle", both_cnt - b_both, 1);
    check_eq("simul_debug4", 32'(both_dbg), 1);
    check_eq("simul_level", 32'(level), 32'b11);
    check_eq("simul_long0", long_cnt[0] - b_long[0], 1);
    check_eq("simul_long1", long_cnt[1] - b_long[1], 1);

    // Reset mid-press while HELD: level drops with no release pulse.
    snap();
    reset = 1'b1;
    step(1);
    mark  = cyc;
    reset = 1'b0;
    check_eq("midrst_level", 32'(level), 0);
    check_eq("midrst_release", 32'(release_pulse), 0);
    check_eq("midrst_long", 32'(long_press), 0);
    step(20);
    check_eq("midrst_repress0", press_cnt[0] - b_press[0], 1);
    check_eq("midrst_repress_latency", press_cyc[0] - mark, 12);
    check_eq("midrst_no_release0", rel_cnt[0] - b_rel[0], 0);
    check_eq("midrst_no_release1", rel_cnt[1] - b_rel[1], 0);
    check_eq("midrst_level_after", 32'(level), 32'b11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
